soc_boot_rom_wb: RTL and testbench
==================================

SOC_BOOT_ROM_WB -- requirements
Module: soc_boot_rom_wb

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, meaning Wishbone address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning data word width.
REQ-003 SHALL have parameter DEPTH_LOG2, default 4, meaning log2 of stored word count (DEPTH = 2**DEPTH_LOG2).
REQ-004 SHALL have parameter BASE, default 24'hffe000, meaning first word address of the window; aligned to 2**(DEPTH_LOG2+1).
REQ-005 SHALL have parameter WAIT_STATES, default 1, range 0..15, meaning idle cycles between strobe capture and ack.
REQ-006 SHALL have port i_clk, input, 1, meaning single clock; all state on rising edge.
REQ-007 SHALL have port i_rst, input, 1, meaning reset, asynchronous, active-high.
REQ-008 SHALL have port i_wb_cyc, input, 1, meaning bus cycle valid.
REQ-009 SHALL have port i_wb_stb, input, 1, meaning slave strobe.
REQ-010 SHALL have port i_wb_we, input, 1, meaning 1 = write.
REQ-011 SHALL have port i_wb_adr, input, ADDR_W, meaning word address.
REQ-012 SHALL have port i_wb_dat, input, DATA_W, meaning write data.
REQ-013 SHALL have port o_wb_dat, output, DATA_W, meaning read data, valid only while o_wb_ack=1.
REQ-014 SHALL have port o_wb_ack, output, 1, meaning normal termination, single-cycle pulse.
REQ-015 SHALL have port o_wb_err, output, 1, meaning error termination, single-cycle pulse.
REQ-016 SHALL have port o_locked, output, 1, meaning storage write-protected.

Function
REQ-017 SHALL decode offset = i_wb_adr - BASE; offsets 0..DEPTH-1 = storage words, offset DEPTH = control word, DEPTH+1..2*DEPTH-1 = reserved; addresses outside BASE..BASE+2*DEPTH-1 are not selected and SHALL be ignored (no ack, no err).
REQ-018 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; IDLE captures address, we, data when i_wb_cyc & i_wb_stb & selected.
REQ-019 SHALL, with WAIT_STATES=0, skip WAIT: ack/err in cycle after capture (latency 1); otherwise latency = WAIT_STATES+1 cycles.
REQ-020 SHALL count WAIT with a 4-bit down-counter loaded with WAIT_STATES-1; leave WAIT when counter = 0.
REQ-021 SHALL abort to IDLE with no ack/err and no storage update if i_wb_cyc or i_wb_stb drops during WAIT.
REQ-022 SHALL assert exactly one of o_wb_ack / o_wb_err for one cycle in RESP, then return to IDLE; no new capture in RESP cycle.
REQ-023 SHALL, on storage read, drive o_wb_dat = stored word, ack.
REQ-024 SHALL, on storage write with o_locked=0, update word at RESP cycle, ack; with o_locked=1, leave word unchanged, err.
REQ-025 SHALL, on control read, drive o_wb_dat = {zeros, o_locked}, ack.
REQ-026 SHALL, on control write, set o_locked when i_wb_dat[0]=1; lock is sticky; writing 0 SHALL NOT clear it; always ack.
REQ-027 SHALL, on any reserved-offset access, err with o_wb_dat = 0.
REQ-028 SHALL drive o_wb_dat = 0 whenever o_wb_ack = 0.
REQ-029 SHALL use DEPTH_LOG2 low offset bits as storage index; no wrap beyond DEPTH (decoded per REQ-017).

Reset
REQ-030 SHALL, on i_rst=1, asynchronously force FSM IDLE, counter 0, o_wb_ack=0, o_wb_err=0, o_wb_dat=0, o_locked=0, all storage words 0.
REQ-031 SHALL discard any in-flight transaction on reset mid-operation; no ack/err after reset release for it.
REQ-032 SHALL accept a new strobe in first cycle after i_rst deasserts.

Verification
REQ-033 Write 16'h0004 to ffe002, read ffe002 (WAIT_STATES=1) -> ack 2 cycles after strobe each, read data 16'h0004.
REQ-034 Write 1 to ffe010, read ffe010 -> o_locked=1, data 16'h0001; write 16'h0001 to ffe002 -> err, readback 16'h0004.
REQ-035 Access ffe011 and ffe01f -> err, o_wb_dat=0; access ffe020 and ffdfff -> no ack, no err for 8 cycles.
REQ-036 Drop i_wb_stb during WAIT (WAIT_STATES=3) on write to ffe005 -> no ack/err, word stays 0.
REQ-037 Assert i_rst during WAIT after lock -> o_locked=0, no ack; read ffe002 -> 16'h0000.
REQ-038 WAIT_STATES=0, back-to-back reads with stb held -> ack every second cycle, one per transaction.

Source files
------------

// File: rtl/soc_boot_rom_wb.sv
// Small write-protectable boot ROM on a Wishbone classic slave port.
// Words sit at BASE..BASE+DEPTH-1; a sticky lock bit lives in the control word at BASE+DEPTH.
module soc_boot_rom_wb #(
   parameter int                ADDR_W      = 24,
   parameter int                DATA_W      = 16,
   parameter int                DEPTH_LOG2  = 4,
   parameter logic [ADDR_W-1:0] BASE        = 24'hffe000,
   parameter int                WAIT_STATES = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wb_cyc,
   input  logic              i_wb_stb,
   input  logic              i_wb_we,
   input  logic [ADDR_W-1:0] i_wb_adr,
   input  logic [DATA_W-1:0] i_wb_dat,
   output logic [DATA_W-1:0] o_wb_dat,
   output logic              o_wb_ack,
   output logic              o_wb_err,
   output logic              o_locked
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam int OFF_W = DEPTH_LOG2 + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [3:0]       CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
   localparam logic [OFF_W-1:0] CTRL_OFF = OFF_W'(DEPTH);
   localparam bit               NO_WAIT  = (WAIT_STATES == 0);

   logic [1:0]            state_reg;
   logic [3:0]            cnt_reg;
   logic [OFF_W-1:0]      off_reg;
   logic                  we_reg;
   logic [DATA_W-1:0]     wdat_reg;
   logic                  ack_reg;
   logic                  err_reg;
   logic [DATA_W-1:0]     dat_reg;
   logic                  locked_reg;
   logic [DATA_W-1:0]     mem [DEPTH];

   logic [ADDR_W-1:0]     offset;
   logic                  live;
   logic                  selected;
   logic                  req;
   logic                  fire;

   logic [OFF_W-1:0]      src_off;
   logic                  src_we;
   logic [DATA_W-1:0]     src_dat;
   logic [DEPTH_LOG2-1:0] idx;

   logic                  resp_ack;
   logic                  resp_err;
   logic [DATA_W-1:0]     resp_dat;
   logic                  do_store;
   logic                  do_lock;

   // Addresses below BASE wrap to huge offsets, so one upper-bits test covers both sides of the window.
   assign offset   = i_wb_adr - BASE;
   assign selected = (offset[ADDR_W-1:OFF_W] == '0);
   assign live     = i_wb_cyc & i_wb_stb;
   assign req      = live & selected;

   // Zero-wait transactions resolve straight from the bus; otherwise from the captured request.
   always_comb begin
      src_off = off_reg;
      src_we  = we_reg;
      src_dat = wdat_reg;
      if (state_reg == S_IDLE) begin
         src_off = offset[OFF_W-1:0];
         src_we  = i_wb_we;
         src_dat = i_wb_dat;
      end
   end

   assign idx  = src_off[DEPTH_LOG2-1:0];
   assign fire = ((state_reg == S_IDLE) && req && NO_WAIT) ||
                 ((state_reg == S_WAIT) && live && (cnt_reg == 4'd0));

   always_comb begin
      resp_ack = 1'b0;
      resp_err = 1'b0;
      resp_dat = '0;
      do_store = 1'b0;
      do_lock  = 1'b0;
      if (!src_off[OFF_W-1]) begin
         if (!src_we) begin
            resp_ack = 1'b1;
            resp_dat = mem[idx];
         end else if (locked_reg) begin
            resp_err = 1'b1;
         end else begin
            resp_ack = 1'b1;
            do_store = 1'b1;
         end
      end else if (src_off == CTRL_OFF) begin
         resp_ack = 1'b1;
         if (!src_we) begin
            resp_dat = DATA_W'(locked_reg);
         end else begin
            do_lock = src_dat[0];
         end
      end else begin
         resp_err = 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg  <= S_IDLE;
         cnt_reg    <= 4'd0;
         off_reg    <= '0;
         we_reg     <= 1'b0;
         wdat_reg   <= '0;
         ack_reg    <= 1'b0;
         err_reg    <= 1'b0;
         dat_reg    <= '0;
         locked_reg <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         ack_reg <= 1'b0;
         err_reg <= 1'b0;
         dat_reg <= '0;
         case (state_reg)
            S_IDLE: begin
               if (req) begin
                  off_reg  <= offset[OFF_W-1:0];
                  we_reg   <= i_wb_we;
                  wdat_reg <= i_wb_dat;
                  if (NO_WAIT) begin
                     state_reg <= S_RESP;
                  end else begin
                     state_reg <= S_WAIT;
                     cnt_reg   <= CNT_LOAD;
                  end
               end
            end
            S_WAIT: begin
               if (!live) begin
                  state_reg <= S_IDLE;
                  cnt_reg   <= 4'd0;
               end else if (cnt_reg == 4'd0) begin
                  state_reg <= S_RESP;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            S_RESP: begin
               state_reg <= S_IDLE;
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
         // The response and any side effect land together, so the RESP cycle is the commit point.
         if (fire) begin
            ack_reg <= resp_ack;
            err_reg <= resp_err;
            dat_reg <= resp_dat;
            if (do_store) begin
               mem[idx] <= src_dat;
            end
            if (do_lock) begin
               locked_reg <= 1'b1;
            end
         end
      end
   end

   assign o_wb_ack = ack_reg;
   assign o_wb_err = err_reg;
   assign o_wb_dat = dat_reg;
   assign o_locked = locked_reg;

endmodule

// File: tb/tb_soc_boot_rom_wb.sv
// Bench for soc_boot_rom_wb: three instances (1, 3 and 0 wait states), directed table,
// multi-cycle corner sequences and randomized traffic against a rule-level model.
module tb_soc_boot_rom_wb;

   logic              clk = 1'b0;
   logic              rst;
   logic [2:0]        cyc;
   logic [2:0]        stb;
   logic [2:0]        we;
   logic [2:0][23:0]  adr;
   logic [2:0][15:0]  wdat;
   logic [2:0][15:0]  rdat;
   logic [2:0]        ack;
   logic [2:0]        err;
   logic [2:0]        locked;

   int checks = 0;
   int errors = 0;

   logic [15:0] mmem [3][16];
   bit          mlock [3];

   typedef struct {
      logic [23:0] a;
      logic        w;
      logic [15:0] d;
      logic        e_ack;
      logic        e_err;
      logic [15:0] e_dat;
   } vec_t;

   vec_t vecs [14];

   always #5 clk = ~clk;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_dut
         soc_boot_rom_wb #(
            .ADDR_W      (24),
            .DATA_W      (16),
            .DEPTH_LOG2  (4),
            .BASE        (24'hffe000),
            .WAIT_STATES ((gi == 0) ? 1 : ((gi == 1) ? 3 : 0))
         ) dut (
            .i_clk    (clk),
            .i_rst    (rst),
            .i_wb_cyc (cyc[gi]),
            .i_wb_stb (stb[gi]),
            .i_wb_we  (we[gi]),
            .i_wb_adr (adr[gi]),
            .i_wb_dat (wdat[gi]),
            .o_wb_dat (rdat[gi]),
            .o_wb_ack (ack[gi]),
            .o_wb_err (err[gi]),
            .o_locked (locked[gi])
         );
      end
   endgenerate

   function automatic int ws_of(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic start(input int k, input logic [23:0] a, input logic w, input logic [15:0] d);
      cyc[k]  = 1'b1;
      stb[k]  = 1'b1;
      adr[k]  = a;
      we[k]   = w;
      wdat[k] = d;
   endtask

   task automatic drop(input int k);
      cyc[k] = 1'b0;
      stb[k] = 1'b0;
      we[k]  = 1'b0;
   endtask

   task automatic wait_resp(input int k, output logic g_ack, output logic g_err,
                            output logic [15:0] g_dat, output int lat);
      lat   = -1;
      g_ack = 1'b0;
      g_err = 1'b0;
      g_dat = '0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (ack[k] || err[k]) begin
            lat   = n;
            g_ack = ack[k];
            g_err = err[k];
            g_dat = rdat[k];
            break;
         end
      end
      drop(k);
      if (lat < 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: dut %0d gave no ack/err within 40 cycles", k);
      end else begin
         @(posedge clk);
         #1;
         check("pulse_width", 32'({ack[k], err[k]}), 32'd0);
      end
   endtask

   task automatic do_txn(input int k, input logic [23:0] a, input logic w, input logic [15:0] d,
                         output logic g_ack, output logic g_err, output logic [15:0] g_dat,
                         output int lat);
      @(negedge clk);
      start(k, a, w, d);
      wait_resp(k, g_ack, g_err, g_dat, lat);
      $display("txn dut=%0d adr=%h we=%0d wdat=%h -> ack=%0d err=%0d rdat=%h lat=%0d",
               k, a, w, d, g_ack, g_err, g_dat, lat);
   endtask

   task automatic no_resp(input int k, input logic [23:0] a, input int n);
      logic seen;
      seen = 1'b0;
      @(negedge clk);
      start(k, a, 1'($urandom_range(0, 1)), 16'h1234);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (ack[k] || err[k]) seen = 1'b1;
      end
      drop(k);
      $display("txn dut=%0d adr=%h unselected -> response_seen=%0d over %0d cycles", k, a, seen, n);
      check("unselected", 32'(seen), 32'd0);
   endtask

   // Rule-level model: decode by offset into the window and apply the access rules directly.
   task automatic model(input int k, input logic [23:0] a, input logic w, input logic [15:0] d,
                        output bit sel, output logic e_ack, output logic e_err,
                        output logic [15:0] e_dat);
      logic [23:0] off;
      off   = a - 24'hffe000;
      sel   = 1'b1;
      e_ack = 1'b0;
      e_err = 1'b0;
      e_dat = '0;
      if (off >= 24'd32) begin
         sel = 1'b0;
      end else if (off < 24'd16) begin
         if (!w) begin
            e_ack = 1'b1;
            e_dat = mmem[k][off[3:0]];
         end else if (mlock[k]) begin
            e_err = 1'b1;
         end else begin
            e_ack = 1'b1;
            mmem[k][off[3:0]] = d;
         end
      end else if (off == 24'd16) begin
         e_ack = 1'b1;
         if (!w) e_dat = {15'd0, mlock[k]};
         else if (d[0]) mlock[k] = 1'b1;
      end else begin
         e_err = 1'b1;
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         mlock[k] = 1'b0;
         for (int i = 0; i < 16; i++) mmem[k][i] = '0;
      end
   endtask

   initial begin
      logic        g_ack, g_err, e_ack, e_err, seen;
      logic [15:0] g_dat, e_dat, d;
      logic [23:0] a;
      logic        w;
      int          lat, r, acks;
      bit          sel;

      vecs[0]  = '{24'hffe002, 1'b1, 16'h0004, 1'b1, 1'b0, 16'h0000};
      vecs[1]  = '{24'hffe002, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0004};
      vecs[2]  = '{24'hffe00f, 1'b1, 16'hbeef, 1'b1, 1'b0, 16'h0000};
      vecs[3]  = '{24'hffe00f, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hbeef};
      vecs[4]  = '{24'hffe010, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
      vecs[5]  = '{24'hffe010, 1'b1, 16'h0001, 1'b1, 1'b0, 16'h0000};
      vecs[6]  = '{24'hffe010, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001};
      vecs[7]  = '{24'hffe002, 1'b1, 16'h0001, 1'b0, 1'b1, 16'h0000};
      vecs[8]  = '{24'hffe002, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0004};
      vecs[9]  = '{24'hffe010, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000};
      vecs[10] = '{24'hffe010, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001};
      vecs[11] = '{24'hffe011, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000};
      vecs[12] = '{24'hffe01f, 1'b1, 16'h5555, 1'b0, 1'b1, 16'h0000};
      vecs[13] = '{24'hffe01f, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000};

      rst  = 1'b1;
      cyc  = '0;
      stb  = '0;
      we   = '0;
      adr  = '0;
      wdat = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check("reset_ack", 32'(ack[k]), 32'd0);
         check("reset_err", 32'(err[k]), 32'd0);
         check("reset_dat", 32'(rdat[k]), 32'd0);
         check("reset_locked", 32'(locked[k]), 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;

      // Directed table on the one-wait-state instance: latency is always two cycles.
      for (int i = 0; i < 14; i++) begin
         do_txn(0, vecs[i].a, vecs[i].w, vecs[i].d, g_ack, g_err, g_dat, lat);
         check($sformatf("vec%0d_ack", i), 32'(g_ack), 32'(vecs[i].e_ack));
         check($sformatf("vec%0d_err", i), 32'(g_err), 32'(vecs[i].e_err));
         check($sformatf("vec%0d_dat", i), 32'(g_dat), 32'(vecs[i].e_dat));
         check($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
      end
      check("locked_after_table", 32'(locked[0]), 32'd1);

      no_resp(0, 24'hffe020, 8);
      no_resp(0, 24'hffdfff, 8);

      // Strobe dropped mid-wait on the three-wait-state instance: write must not land.
      @(negedge clk);
      start(1, 24'hffe005, 1'b1, 16'hffff);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      drop(1);
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (ack[1] || err[1]) seen = 1'b1;
      end
      $display("txn dut=1 adr=ffe005 write aborted in wait -> response_seen=%0d", seen);
      check("abort_no_resp", 32'(seen), 32'd0);
      do_txn(1, 24'hffe005, 1'b0, 16'h0000, g_ack, g_err, g_dat, lat);
      check("abort_readback_ack", 32'(g_ack), 32'd1);
      check("abort_readback_dat", 32'(g_dat), 32'd0);
      check("ws3_lat", 32'(lat), 32'd4);

      // Zero-wait instance with strobe held: one ack every second cycle.
      do_txn(2, 24'hffe003, 1'b1, 16'h00ab, g_ack, g_err, g_dat, lat);
      check("ws0_write_ack", 32'(g_ack), 32'd1);
      check("ws0_lat", 32'(lat), 32'd1);
      @(negedge clk);
      start(2, 24'hffe003, 1'b0, 16'h0000);
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (ack[2]) acks++;
         $display("txn dut=2 adr=ffe003 held-strobe cycle=%0d ack=%0d rdat=%h", i, ack[2], rdat[2]);
         check($sformatf("b2b_ack%0d", i), 32'(ack[2]), 32'((i % 2) == 0));
         check($sformatf("b2b_dat%0d", i), 32'(rdat[2]), ((i % 2) == 0) ? 32'h00ab : 32'd0);
      end
      drop(2);
      check("b2b_ack_count", 32'(acks), 32'd5);
      @(posedge clk);
      #1;

      // Reset landing in the middle of a wait.
      @(negedge clk);
      start(0, 24'hffe002, 1'b0, 16'h0000);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rst_async_locked", 32'(locked[0]), 32'd0);
      check("rst_async_ack", 32'(ack[0]), 32'd0);
      drop(0);
      model_reset();
      seen = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
         if (ack[0] || err[0]) seen = 1'b1;
      end
      check("rst_no_resp", 32'(seen), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      start(0, 24'hffe002, 1'b0, 16'h0000);
      wait_resp(0, g_ack, g_err, g_dat, lat);
      $display("txn dut=0 adr=ffe002 first after reset -> ack=%0d err=%0d rdat=%h lat=%0d",
               g_ack, g_err, g_dat, lat);
      check("post_rst_ack", 32'(g_ack), 32'd1);
      check("post_rst_dat", 32'(g_dat), 32'd0);
      check("post_rst_lat", 32'(lat), 32'd2);
      check("post_rst_locked", 32'(locked[0]), 32'd0);

      // Randomized traffic against the model on every instance.
      for (int k = 0; k < 3; k++) begin
         for (int t = 0; t < 40; t++) begin
            r = int'($urandom_range(0, 99));
            if (r < 65)      a = 24'hffe000 + 24'($urandom_range(0, 15));
            else if (r < 75) a = 24'hffe010;
            else if (r < 90) a = 24'hffe011 + 24'($urandom_range(0, 14));
            else if ($urandom_range(0, 1) == 1) a = 24'hffe020 + 24'($urandom_range(0, 255));
            else             a = 24'hffe000 - 24'($urandom_range(1, 256));
            w = 1'($urandom_range(0, 1));
            d = 16'($urandom);
            if (a == 24'hffe010 && w && $urandom_range(0, 3) != 0) d[0] = 1'b0;
            model(k, a, w, d, sel, e_ack, e_err, e_dat);
            if (!sel) begin
               no_resp(k, a, 4);
            end else begin
               do_txn(k, a, w, d, g_ack, g_err, g_dat, lat);
               check("rnd_ack", 32'(g_ack), 32'(e_ack));
               check("rnd_err", 32'(g_err), 32'(e_err));
               check("rnd_dat", 32'(g_dat), 32'(e_dat));
               check("rnd_lat", 32'(lat), 32'(ws_of(k) + 1));
               check("rnd_locked", 32'(locked[k]), 32'(mlock[k]));
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
